// File: rtl/c_bus_writeback_ctrl.sv
// C-bus writeback controller: decodes the microinstruction C field into register
// write enables and delays them through a stallable, flushable pipeline.
module c_bus_writeback_ctrl #(
    parameter int N_DEST  = 9,
    parameter int ENCODED = 1,
    parameter int SEL_W   = 4,
    parameter int LATENCY = 2,
    localparam int CF_W   = (ENCODED != 0) ? SEL_W : N_DEST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [CF_W-1:0]   c_field_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              clr_err_i,
    output logic [N_DEST-1:0] c_en_o,
    output logic              valid_o,
    output logic [N_DEST-1:0] pending_o,
    output logic              illegal_o
);

    logic [N_DEST-1:0]              dec_mask;
    logic                           dec_illegal;
    logic [LATENCY-1:0]             vld_q;
    logic [LATENCY-1:0][N_DEST-1:0] mask_q;
    logic                           illegal_q;
    logic                           advance;

    generate
        if (ENCODED != 0) begin : g_enc
            // Out-of-range indices decode to an empty mask but still occupy a slot.
            always_comb begin
                dec_mask = '0;
                for (int i = 0; i < N_DEST; i++) begin
                    dec_mask[i] = (int'(c_field_i) == i);
                end
                dec_illegal = (int'(c_field_i) >= N_DEST);
            end
        end else begin : g_mask
            always_comb begin
                dec_mask    = c_field_i;
                dec_illegal = 1'b0;
            end
        end
    endgenerate

    assign advance = !stall_i && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            mask_q <= '0;
        end else if (flush_i) begin
            vld_q <= '0;
        end else if (!stall_i) begin
            vld_q[0]  <= valid_i;
            mask_q[0] <= dec_mask;
            for (int k = 1; k < LATENCY; k++) begin
                vld_q[k]  <= vld_q[k-1];
                mask_q[k] <= mask_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (advance && valid_i && dec_illegal) begin
            illegal_q <= 1'b1;
        end else if (clr_err_i) begin
            illegal_q <= 1'b0;
        end
    end

    always_comb begin
        pending_o = '0;
        for (int k = 0; k < LATENCY; k++) begin
            if (vld_q[k]) begin
                pending_o = pending_o | mask_q[k];
            end
        end
    end

    // Suppressed while stalled or flushed so a held entry commits exactly once.
    assign c_en_o    = (vld_q[LATENCY-1] && advance) ? mask_q[LATENCY-1] : '0;
    assign valid_o   = vld_q[LATENCY-1];
    assign illegal_o = illegal_q;

endmodule
